// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM state encoding and counter-width helper for seq_multiplier
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/seq_mul_abs.sv
// seq_mul_abs: combinational two's-complement magnitude; a = input, mag = |a| as unsigned (min value maps to 2^(WIDTH-1))
module seq_mul_abs #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] mag
);
  assign mag = a[WIDTH-1] ? -a : a;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per clock; start/A/B in, C (2xWIDTH) with busy and done strobe out; SEQ_MUL_SIGNED_EN adds signed_mode
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done
);
  localparam int CW = cnt_w(WIDTH);
  state_t             state;
  logic [2*WIDTH-1:0] mcand, acc, acc_next, res;
  logic [WIDTH-1:0]   mplier, op_a, op_b;
  logic [CW-1:0]      cnt;
`ifdef SEQ_MUL_SIGNED_EN
  logic               sign;
  logic [WIDTH-1:0]   mag_a, mag_b;
  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_a (.a(A), .mag(mag_a));
  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_b (.a(B), .mag(mag_b));
  assign op_a = signed_mode ? mag_a : A;
  assign op_b = signed_mode ? mag_b : B;
  assign res  = sign ? -acc_next : acc_next;
`else
  assign op_a = A;
  assign op_b = B;
  assign res  = acc_next;
`endif
  assign acc_next = mplier[0] ? acc + mcand : acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      C      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      sign   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            C     <= res;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state  <= RUN;
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
            sign   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: randomized self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, start8 = 1'b0, sm = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  a8 = '0, b8 = '0, c4;
  logic [15:0] c8;
  logic        busy4, done4, busy8, done8;
  int          pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  seq_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_mode(sm),
`endif
    .C(c4), .busy(busy4), .done(done4)
  );
  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .C(c8), .busy(busy8), .done(done8)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    return 8'(x * y);
  endfunction
  task automatic wait_done4(input string tag, output int lat);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done4 && lat < 4) begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
      end
    end
    check({tag, "_lat"}, lat, 4);
  endtask
  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s);
    int lat;
    logic [7:0] exp;
    exp = ref4(a, b, s);
    @(negedge clk);
    a4 = a; b4 = b; sm = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check({tag, "_busy"}, busy4, 1);
    wait_done4(tag, lat);
    check({tag, "_c"}, c4, exp);
    check({tag, "_busy_done"}, busy4, 0);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, done4, 0);
    check({tag, "_c_hold"}, c4, exp);
  endtask
  initial begin
    int lat, seen;
    logic [3:0] ra, rb;
    logic rs;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c", c4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    rst = 1'b0;
    run4("z0", 4'd0, 4'd15, 1'b0);
    run4("z1", 4'd1, 4'd15, 1'b0);
    run4("z2", 4'd2, 4'd2, 1'b0);
    run4("z3", 4'd3, 4'd3, 1'b0);
    run4("max4", 4'd15, 4'd15, 1'b0);
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin @(posedge clk); #1; lat++; end
    check("max8_lat", lat, 8);
    check("max8_c", c8, 65025);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 30) begin @(posedge clk); #1; lat++; end
      check("rnd8_lat", lat, 8);
      check("rnd8_c", c8, 32'(a8) * 32'(b8));
    end
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd6; sm = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd9;
    lat = 0;
    while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b2b1_lat", lat, 4);
    check("b2b1_c", c4, 30);
    @(posedge clk); #1;
    start4 = 1'b0;
    check("b2b_no_bubble", busy4, 1);
    check("b2b_done_drop", done4, 0);
    lat = 0;
    while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b2b2_lat", lat, 4);
    check("b2b2_c", c4, 63);
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("ign_busy", busy4, 1);
    lat = 2;
    while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("ign_lat", lat, 4);
    check("ign_c", c4, 9);
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_c", c4, 0);
    check("mrst_busy", busy4, 0);
    check("mrst_done", done4, 0);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen += int'(done4); end
    check("mrst_no_done", seen, 0);
    run4("after_rst", 4'd2, 4'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1; start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    @(posedge clk); #1;
    rst = 1'b0; start4 = 1'b0;
    check("rst_wins_busy", busy4, 0);
    check("rst_wins_c", c4, 0);
`ifdef SEQ_MUL_SIGNED_EN
    run4("s_m8m8", 4'd8, 4'd8, 1'b1);
    run4("s_m1x3", 4'd15, 4'd3, 1'b1);
    run4("s_off", 4'd15, 4'd15, 1'b0);
`endif
    for (int i = 0; i < 12; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
`ifdef SEQ_MUL_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run4("rnd4", ra, rb, rs);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier that replaces the combinational 4×4 `Multiplier` wherever operand width grows beyond what a single-cycle array fits. Accepts an operand pair on a start pulse and iterates one partial product per clock. Presents a 2×WIDTH product with a one-cycle done strobe. Optional signed (two's-complement) mode is compiled in by macro.

## Interface
- WIDTH, 4, operand width in bits (≥2); product is 2×WIDTH
- clk  input  1  rising-edge clock; one clock domain only
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block can accept (IDLE or DONE)
- A  input  WIDTH  multiplicand, sampled with accepted start
- B  input  WIDTH  multiplier, sampled with accepted start
- signed_mode  input  1  present only with SEQ_MUL_SIGNED_EN; sampled with accepted start
- C  output  2×WIDTH  product; holds last result until the next accepted start
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle strobe: C valid and new this cycle

## Operation
- States: IDLE, RUN, DONE (encoding in package)
- IDLE: busy=0, done=0; start=1 → latch A into mcand (2×WIDTH, zero-extended), B into mplier, acc←0, cnt←WIDTH, → RUN
- RUN: each cycle: if mplier[0] then acc←acc+mcand; mcand←mcand<<1; mplier←mplier>>1; cnt←cnt−1; when cnt reaches 1 on this edge → DONE, C←final acc
- DONE: done=1 for exactly one cycle; start=1 here is accepted as in IDLE (back-to-back, no bubble) → RUN; else → IDLE
- start during RUN ignored, no queueing; A/B changes during RUN have no effect
- Arithmetic: unsigned, exact, no overflow possible in 2×WIDTH; adder is 2×WIDTH wide
- Early termination not permitted: latency is fixed regardless of operand values (including zero)
- C updated only on the RUN→DONE edge; otherwise held
- rst anywhere (including mid-RUN): next state IDLE, C=0, busy=0, done=0, all internal registers cleared; in-flight operation discarded, no done issued

## Timing
- Reset values: C=0, busy=0, done=0, state IDLE
- Accepted start at edge k → busy=1 from k; C valid and done=1 in the cycle following edge k+WIDTH; busy=0 in that cycle
- Latency start-edge to done: WIDTH cycles; throughput one product per WIDTH cycles with back-to-back starts
- rst and start asserted together: rst wins
- No combinational path from inputs to outputs; all outputs registered

## Configuration
- SEQ_MUL_SIGNED_EN defined: signed_mode port exists; when signed_mode=1 at accept, A and B are two's-complement; block latches |A|, |B| and sign = A[MSB]^B[MSB], runs the same unsigned loop, and negates acc on the RUN→DONE edge if sign set; C is a 2×WIDTH two's-complement product. −2^(WIDTH−1) magnitude handled as unsigned WIDTH-bit value. Latency unchanged
- Undefined: no signed_mode port, no sign logic; pure unsigned behaviour as above

## Structure
- Package seq_mul_pkg: state enum (IDLE, RUN, DONE), counter width localparam as $clog2(WIDTH+1) helper function
- Natural sub-module: seq_mul_abs (combinational WIDTH-bit two's-complement magnitude), instantiated twice, only under SEQ_MUL_SIGNED_EN; FSM, counter and datapath stay in seq_multiplier

## Test plan
- WIDTH=4, rst then start with A=0,B=15 / A=1,B=15 / A=2,B=2 / A=3,B=3 → C=0, 15, 4, 9, each with done exactly 4 cycles after start edge
- WIDTH=4, A=15,B=15 → C=225; then WIDTH=8, A=255,B=255 → C=65025 after 8 cycles
- Back-to-back: start held high, operand pairs (5,6),(7,9) → done strobes every 4 cycles, C=30 then 63, no idle cycle between
- start with A=3,B=3, then start with A=15,B=15 two cycles later → second ignored, C=9, busy stays 1 until done
- rst asserted at cycle 2 of RUN → next cycle C=0, busy=0, done=0, no done strobe; subsequent 2×3 → C=6
- SEQ_MUL_SIGNED_EN, WIDTH=4, signed_mode=1: (−8)×(−8) → C=8'h40; (−1)×3 → C=8'hFD; signed_mode=0 with 15×15 → C=225
